// File: rtl/alu_pkg.sv
// Shared opcode, flag and FIFO-depth definitions for the ALU request responder.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  localparam int FLG_ZERO  = 3;
  localparam int FLG_NEG   = 2;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 0;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } flags_t;

  localparam int RESP_DEPTH = 2;

endpackage

// File: rtl/alu_exec.sv
// Combinational 8-op ALU core; opcodes 8-15 flag illegal and yield zero.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output flags_t           flags,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
  logic [SH_W-1:0] shamt;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    shamt  = b[SH_W-1:0];
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        result      = sum[WIDTH-1:0];
        flags.carry = sum[WIDTH];
        flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // top bit of the widened difference is the borrow
        result      = diff[WIDTH-1:0];
        flags.carry = diff[WIDTH];
        flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      default: result = '0;
    endcase
    flags.zero = (result == '0);
    flags.neg  = result[WIDTH-1];
  end

  assign illegal = op[3];

endmodule

// File: rtl/alu_req_responder.sv
// Flow-controlled ALU front-end: request register, ALU, 2-entry response FIFO.
// Define ALU_ERR_RESP_EN to report opcodes 8-15 on resp_err.
module alu_req_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_neg,
  output logic             resp_carry,
  output logic             resp_ovf,
  output logic             resp_err,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic [15:0]      resp_count
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    flags_t           flags;
`ifdef ALU_ERR_RESP_EN
    logic             err;
`endif
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [3:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic [WIDTH-1:0] ex_result;
  flags_t           ex_flags;
`ifdef ALU_ERR_RESP_EN
  logic             ex_illegal;
`endif

  entry_t           mem [RESP_DEPTH];
  entry_t           push_entry, head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop, advance, req_fire;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  alu_exec #(.WIDTH(WIDTH)) u_exec (
    .a       (s1_a),
    .b       (s1_b),
    .op      (s1_op),
    .result  (ex_result),
    .flags   (ex_flags),
`ifdef ALU_ERR_RESP_EN
    .illegal (ex_illegal)
`else
    .illegal ()
`endif
  );

  // a pop frees a slot in the same cycle, so a full FIFO can still accept
  assign resp_valid = (count != '0);
  assign pop        = resp_valid && resp_ready;
  assign advance    = s1_valid && ((count < CNT_W'(RESP_DEPTH)) || pop);
  assign req_ready  = !s1_valid || advance;
  assign req_fire   = req_valid && req_ready;
  assign busy       = s1_valid || resp_valid;

  always_comb begin
    push_entry        = '0;
    push_entry.result = ex_result;
    push_entry.flags  = ex_flags;
`ifdef ALU_ERR_RESP_EN
    push_entry.err    = ex_illegal;
`endif
    push_entry.tag    = s1_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
    end else if (req_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= req_a;
      s1_b     <= req_b;
      s1_op    <= req_op;
      s1_tag   <= req_tag;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RESP_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (advance) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({advance, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             resp_count <= '0;
    else if (pop && resp_count != '1)    resp_count <= resp_count + 16'd1;
  end

  assign head        = mem[rd_ptr];
  assign resp_result = head.result;
  assign resp_zero   = head.flags.zero;
  assign resp_neg    = head.flags.neg;
  assign resp_carry  = head.flags.carry;
  assign resp_ovf    = head.flags.ovf;
  assign resp_tag    = head.tag;
`ifdef ALU_ERR_RESP_EN
  assign resp_err    = head.err;
`else
  assign resp_err    = 1'b0;
`endif

endmodule
